contador_multi: RTL

Parametrised pop-count monitor for the output stage. It keeps one saturating word counter per output FIFO plus a total pop counter, and answers indexed read requests with a registered, one-cycle-latency response, but only while the output stage reports IDLE. Optional clear-on-read makes each read return the words drained since the previous read of that channel. It sits beside the output FIFOs, fed by their pop strobes and the IDLE flag from the output state machine.

---
 rtl/contador_multi_pkg.sv | 20 ++
 rtl/contador_canal.sv | 45 ++++
 rtl/contador_multi.sv | 112 +++++++++++
 3 files changed

// File: rtl/contador_multi_pkg.sv
// Shared defaults for the output-stage pop-count monitor and the
// index-width helper used to size the channel selector.
package contador_multi_pkg;

  localparam int FIFO_UNITS_DEF  = 4;
  localparam int CNT_W_DEF       = 5;
  localparam int TOT_W_DEF       = 7;
  localparam int CLR_ON_READ_DEF = 0;

  // Smallest r with 2**r >= value; never returns less than 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_canal.sv
// One saturating per-FIFO word counter with a sticky saturation flag,
// cleared globally or by an accepted clear-on-read.
module contador_canal #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr_read,
  input  logic             clr_all,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  // Counter and sticky flag; a pop landing with the read clear still counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= CNT_ZERO;
      sat_r <= 1'b0;
    end else if (clr_all) begin
      cnt_r <= CNT_ZERO;
      sat_r <= 1'b0;
    end else if (clr_read) begin
      cnt_r <= inc ? CNT_ONE : CNT_ZERO;
      sat_r <= 1'b0;
    end else if (inc) begin
      if (cnt_r == CNT_MAX) begin
        sat_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign cnt = cnt_r;
  assign sat = sat_r;

endmodule

// File: rtl/contador_multi.sv
// Pop-count monitor: per-FIFO saturating counters, a saturating total, and
// registered indexed reads that are only honoured while the output stage is idle.
module contador_multi
  import contador_multi_pkg::*;
#(
  parameter int FIFO_UNITS  = FIFO_UNITS_DEF,
  parameter int INDEX       = clog2_f(FIFO_UNITS),
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOT_W       = TOT_W_DEF,
  parameter int CLR_ON_READ = CLR_ON_READ_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIFO_UNITS-1:0] pop_vec,
  input  logic                  pop,
  input  logic                  idle,
  input  logic                  req,
  input  logic [INDEX-1:0]      idx,
  input  logic                  clr_all,
  output logic [CNT_W-1:0]      cuenta,
  output logic [TOT_W-1:0]      total,
  output logic                  sat,
  output logic                  valid,
  output logic                  err
);

  localparam logic [INDEX:0]   UNITS_L  = (INDEX+1)'(FIFO_UNITS);
  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};
  localparam logic [TOT_W-1:0] TOT_ONE  = {{(TOT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]      cnt_s [FIFO_UNITS];
  logic [FIFO_UNITS-1:0] sat_s;
  logic                  accept_s;
  logic [CNT_W-1:0]      sel_cnt_s;
  logic                  sel_sat_s;

  logic [TOT_W-1:0] tot_cnt_r;
  logic [CNT_W-1:0] cuenta_r;
  logic [TOT_W-1:0] total_r;
  logic             sat_r;
  logic             valid_r;
  logic             err_r;

  // Read decode and channel select; the select is a compare loop so an
  // out-of-range idx never indexes past the counter array.
  always_comb begin
    accept_s  = req & idle & ({1'b0, idx} < UNITS_L);
    sel_cnt_s = CNT_ZERO;
    sel_sat_s = 1'b0;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      if (idx == INDEX'(i)) begin
        sel_cnt_s = cnt_s[i];
        sel_sat_s = sat_s[i];
      end else begin
        sel_cnt_s = sel_cnt_s;
        sel_sat_s = sel_sat_s;
      end
    end
  end

  for (genvar g = 0; g < FIFO_UNITS; g++) begin : g_canal
    logic clr_read_s;
    assign clr_read_s = (CLR_ON_READ != 0) && accept_s && (idx == INDEX'(g));

    contador_canal #(.CNT_W(CNT_W)) u_canal (
      .clk      (clk),
      .reset    (reset),
      .inc      (pop_vec[g]),
      .clr_read (clr_read_s),
      .clr_all  (clr_all),
      .cnt      (cnt_s[g]),
      .sat      (sat_s[g])
    );
  end

  // Total pop counter; reads never clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tot_cnt_r <= TOT_ZERO;
    end else if (clr_all) begin
      tot_cnt_r <= TOT_ZERO;
    end else if (pop && (tot_cnt_r != TOT_MAX)) begin
      tot_cnt_r <= tot_cnt_r + TOT_ONE;
    end
  end

  // Response registers capture pre-edge counts; zero outside a response cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta_r <= CNT_ZERO;
      total_r  <= TOT_ZERO;
      sat_r    <= 1'b0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      valid_r  <= accept_s;
      err_r    <= req & ~accept_s;
      cuenta_r <= accept_s ? sel_cnt_s : CNT_ZERO;
      total_r  <= accept_s ? tot_cnt_r : TOT_ZERO;
      sat_r    <= accept_s & sel_sat_s;
    end
  end

  assign cuenta = cuenta_r;
  assign total  = total_r;
  assign sat    = sat_r;
  assign valid  = valid_r;
  assign err    = err_r;

endmodule
